// File: rtl/flash_xfer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : flash_xfer_arbiter
// Brief    : Round-robin owner of the shared SPI flash byte engine. Grants
//            one complete transfer (CS assert, TX bytes, RX bytes, CS
//            release) to either the UART (0) or I2C (1) command decoder,
//            with abort support that never cuts the engine mid-byte.
// Revision : 1.0 - initial release
// ============================================================================
module flash_xfer_arbiter #(
    parameter int          LEN_W   = 16,
    parameter int          CS_GAP  = 4,
    parameter logic [7:0]  RX_FILL = 8'h00
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [1:0]           req_valid,
    input  logic [2*LEN_W-1:0]   req_tx_len,
    input  logic [2*LEN_W-1:0]   req_rx_len,
    output logic [1:0]           req_ack,
    input  logic [1:0]           req_abort,
    input  logic [15:0]          tx_data,
    input  logic [1:0]           tx_valid,
    output logic [1:0]           tx_ready,
    output logic [7:0]           rx_data,
    output logic [1:0]           rx_valid,
    input  logic [1:0]           rx_ready,
    output logic [1:0]           owner,
    output logic                 flash_cs_n,
    output logic                 eng_start,
    output logic [7:0]           eng_tx,
    input  logic                 eng_done,
    input  logic [7:0]           eng_rx
);

    localparam int                 c_GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_TX_WAIT  = 3'd2,
        S_TX_SHIFT = 3'd3,
        S_RX_SHIFT = 3'd4,
        S_RX_HOLD  = 3'd5,
        S_DRAIN    = 3'd6,
        S_GAP      = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [LEN_W-1:0]   r_tx_cnt;
    logic [LEN_W-1:0]   r_rx_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic               r_last;
    logic [1:0]         r_owner;
    logic [1:0]         r_req_ack;
    logic               r_cs_n;
    logic [1:0]         r_tx_ready;
    logic [1:0]         r_rx_valid;
    logic [7:0]         r_rx_data;
    logic               r_eng_start;
    logic [7:0]         r_eng_tx;

    logic [LEN_W-1:0]   w_tx_cnt_nxt;
    logic [LEN_W-1:0]   w_rx_cnt_nxt;
    logic [c_GAP_W-1:0] w_gap_cnt_nxt;
    logic               w_grant;
    logic               w_rx_go;
    logic               w_start;
    logic [7:0]         w_eng_tx_nxt;
    logic               w_rx_load;
    logic [1:0]         w_owner_nxt;
    logic               w_idle_nxt;

    // Owner-qualified views of the requester side-band signals.
    logic               w_abort;
    logic               w_tx_valid;
    logic               w_rx_ready;
    logic [7:0]         w_tx_byte;

    // Arbitration: a lone requester wins; a tie goes to the one not granted last.
    logic               w_win;
    logic [1:0]         w_win_onehot;
    logic [LEN_W-1:0]   w_win_tx_len;
    logic [LEN_W-1:0]   w_win_rx_len;

    assign w_abort      = |(req_abort & r_owner);
    assign w_tx_valid   = |(tx_valid & r_owner);
    assign w_rx_ready   = |(rx_ready & r_owner);
    assign w_tx_byte    = r_owner[1] ? tx_data[15:8] : tx_data[7:0];

    assign w_win        = (&req_valid) ? ~r_last : req_valid[1];
    assign w_win_onehot = w_win ? 2'b10 : 2'b01;
    assign w_win_tx_len = w_win ? req_tx_len[2*LEN_W-1:LEN_W] : req_tx_len[LEN_W-1:0];
    assign w_win_rx_len = w_win ? req_rx_len[2*LEN_W-1:LEN_W] : req_rx_len[LEN_W-1:0];

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, counter and engine-command decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_cnt_nxt  = r_tx_cnt;
        w_rx_cnt_nxt  = r_rx_cnt;
        w_gap_cnt_nxt = '0;
        w_grant       = 1'b0;
        w_rx_go       = 1'b0;
        w_start       = 1'b0;
        w_eng_tx_nxt  = r_eng_tx;
        w_rx_load     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_grant = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_abort) begin
                    w_state_nxt = S_GAP;
                end else if (r_tx_cnt != '0) begin
                    w_state_nxt = S_TX_WAIT;
                end else if (r_rx_cnt != '0) begin
                    w_rx_go = 1'b1;
                end else begin
                    w_state_nxt = S_GAP;
                end
            end
            S_TX_WAIT: begin
                if (w_abort) begin
                    w_state_nxt = S_GAP;
                end else if (w_tx_valid) begin
                    w_state_nxt  = S_TX_SHIFT;
                    w_start      = 1'b1;
                    w_eng_tx_nxt = w_tx_byte;
                    w_tx_cnt_nxt = r_tx_cnt - 1'b1;
                end
            end
            S_TX_SHIFT: begin
                // A byte that completes in the abort cycle needs no drain.
                if (eng_done) begin
                    if (w_abort) begin
                        w_state_nxt = S_GAP;
                    end else if (r_tx_cnt != '0) begin
                        w_state_nxt = S_TX_WAIT;
                    end else if (r_rx_cnt != '0) begin
                        w_rx_go = 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end else if (w_abort) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_RX_SHIFT: begin
                if (eng_done) begin
                    if (w_abort) begin
                        w_state_nxt = S_GAP;
                    end else begin
                        w_rx_load   = 1'b1;
                        w_state_nxt = S_RX_HOLD;
                    end
                end else if (w_abort) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_RX_HOLD: begin
                if (w_abort) begin
                    w_state_nxt = S_GAP;
                end else if (w_rx_ready) begin
                    if (r_rx_cnt != '0) begin
                        w_rx_go = 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                    end
                end
            end
            S_DRAIN: begin
                if (eng_done) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                // The IDLE decision is taken in the final gap cycle so that
                // back-to-back transfers see exactly CS_GAP high cycles.
                if (r_gap_cnt == c_GAP_LAST) begin
                    if (|req_valid) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_rx_go) begin
            w_state_nxt  = S_RX_SHIFT;
            w_start      = 1'b1;
            w_eng_tx_nxt = RX_FILL;
            w_rx_cnt_nxt = r_rx_cnt - 1'b1;
        end

        if (w_grant) begin
            w_state_nxt  = S_SETUP;
            w_tx_cnt_nxt = w_win_tx_len;
            w_rx_cnt_nxt = w_win_rx_len;
        end

        w_idle_nxt  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
        w_owner_nxt = w_grant ? w_win_onehot : (w_idle_nxt ? 2'b00 : r_owner);
    end

    // Registered datapath and outputs, all derived from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_cnt    <= '0;
            r_rx_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_last      <= 1'b1;
            r_owner     <= 2'b00;
            r_req_ack   <= 2'b00;
            r_cs_n      <= 1'b1;
            r_tx_ready  <= 2'b00;
            r_rx_valid  <= 2'b00;
            r_rx_data   <= 8'h00;
            r_eng_start <= 1'b0;
            r_eng_tx    <= 8'h00;
        end else begin
            r_tx_cnt    <= w_tx_cnt_nxt;
            r_rx_cnt    <= w_rx_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_last      <= w_grant ? w_win : r_last;
            r_owner     <= w_owner_nxt;
            r_req_ack   <= w_grant ? w_win_onehot : 2'b00;
            r_cs_n      <= w_idle_nxt;
            r_tx_ready  <= (w_state_nxt == S_TX_WAIT) ? w_owner_nxt : 2'b00;
            r_rx_valid  <= (w_state_nxt == S_RX_HOLD) ? w_owner_nxt : 2'b00;
            r_rx_data   <= w_rx_load ? eng_rx : r_rx_data;
            r_eng_start <= w_start;
            r_eng_tx    <= w_eng_tx_nxt;
        end
    end

    assign req_ack    = r_req_ack;
    assign tx_ready   = r_tx_ready;
    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign owner      = r_owner;
    assign flash_cs_n = r_cs_n;
    assign eng_start  = r_eng_start;
    assign eng_tx     = r_eng_tx;

endmodule
`default_nettype wire

// File: tb/tb_flash_xfer_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_flash_xfer_arbiter
// Brief    : Directed bench for flash_xfer_arbiter with a behavioural byte
//            engine, requester drivers and queue-based scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_xfer_arbiter;

    localparam int c_CS_GAP  = 4;
    localparam int c_ENG_LAT = 3;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] rx;
    } req_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [31:0] req_tx_len = '0;
    logic [31:0] req_rx_len = '0;
    logic [1:0]  req_ack;
    logic [1:0]  req_abort = 2'b00;
    logic [15:0] tx_data = '0;
    logic [1:0]  tx_valid = 2'b00;
    logic [1:0]  tx_ready;
    logic [7:0]  rx_data;
    logic [1:0]  rx_valid;
    logic [1:0]  rx_ready = 2'b11;
    logic [1:0]  owner;
    logic        flash_cs_n;
    logic        eng_start;
    logic [7:0]  eng_tx;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_rx = 8'h00;

    int errors = 0;
    int checks = 0;

    // Stimulus queues and scoreboards.
    req_t        req_q0[$], req_q1[$];
    logic [7:0]  tx_q0[$], tx_q1[$];
    logic [7:0]  eng_rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rx0[$], exp_rx1[$];
    logic [1:0]  exp_grant[$];

    // Monitor state.
    int          cyc = 0;
    int          n_start = 0, n_ack = 0, n_rise = 0;
    int          rxv_cnt0 = 0, rxv_cnt1 = 0;
    int          hi_cnt = 0, lo_cnt = 0, last_high_run = 0, last_low_run = 0;
    int          rise_cyc = 0, last_done_cyc = 0;
    logic        prev_cs = 1'b1;
    logic        eng_busy = 1'b0;
    logic [7:0]  start_tx = 8'h00;
    logic [1:0]  tx_hs = 2'b00;
    int          eng_cnt = 0;

    flash_xfer_arbiter #(
        .LEN_W   (16),
        .CS_GAP  (c_CS_GAP),
        .RX_FILL (8'h00)
    ) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_tx_len (req_tx_len),
        .req_rx_len (req_rx_len),
        .req_ack    (req_ack),
        .req_abort  (req_abort),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .owner      (owner),
        .flash_cs_n (flash_cs_n),
        .eng_start  (eng_start),
        .eng_tx     (eng_tx),
        .eng_done   (eng_done),
        .eng_rx     (eng_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester drivers and byte-engine model, updated just after each edge.
    always @(posedge clk) begin
        req_t r;
        #1;
        if (!resetn) begin
            req_valid = 2'b00;
            tx_valid  = 2'b00;
            eng_done  = 1'b0;
            eng_cnt   = 0;
        end else begin
            if (req_ack[0]) req_valid[0] = 1'b0;
            else if (!req_valid[0] && req_q0.size() > 0) begin
                r = req_q0.pop_front();
                req_tx_len[15:0] = r.tx;
                req_rx_len[15:0] = r.rx;
                req_valid[0] = 1'b1;
            end
            if (req_ack[1]) req_valid[1] = 1'b0;
            else if (!req_valid[1] && req_q1.size() > 0) begin
                r = req_q1.pop_front();
                req_tx_len[31:16] = r.tx;
                req_rx_len[31:16] = r.rx;
                req_valid[1] = 1'b1;
            end
            if (tx_hs[0] && tx_q0.size() > 0) void'(tx_q0.pop_front());
            if (tx_hs[1] && tx_q1.size() > 0) void'(tx_q1.pop_front());
            tx_valid[0] = (tx_q0.size() > 0);
            tx_valid[1] = (tx_q1.size() > 0);
            if (tx_q0.size() > 0) tx_data[7:0]  = tx_q0[0];
            if (tx_q1.size() > 0) tx_data[15:8] = tx_q1[0];
            eng_done = 1'b0;
            if (eng_start) eng_cnt = c_ENG_LAT;
            else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_rx   = (eng_rx_q.size() > 0) ? eng_rx_q.pop_front() : 8'hA5;
                end
            end
        end
    end

    // Output monitor and scoreboard comparisons, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] e8;
        logic [1:0] e2;
        cyc++;
        tx_hs = tx_valid & tx_ready;
        if (!resetn) begin
            eng_busy = 1'b0;
        end else begin
            if (eng_start) begin
                n_start++;
                e8 = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'hxx;
                check("eng_tx", {24'h0, eng_tx}, {24'h0, e8});
                start_tx = eng_tx;
                eng_busy = 1'b1;
            end
            if (eng_done) begin
                last_done_cyc = cyc;
                if (eng_busy) check("eng_tx_hold", {24'h0, eng_tx}, {24'h0, start_tx});
                eng_busy = 1'b0;
            end
            if (req_ack != 2'b00) begin
                n_ack++;
                e2 = (exp_grant.size() > 0) ? exp_grant.pop_front() : 2'bxx;
                check("req_ack", {30'h0, req_ack}, {30'h0, e2});
            end
            if (rx_valid[0] && rx_ready[0]) begin
                e8 = (exp_rx0.size() > 0) ? exp_rx0.pop_front() : 8'hxx;
                check("rx_data0", {24'h0, rx_data}, {24'h0, e8});
            end
            if (rx_valid[1] && rx_ready[1]) begin
                e8 = (exp_rx1.size() > 0) ? exp_rx1.pop_front() : 8'hxx;
                check("rx_data1", {24'h0, rx_data}, {24'h0, e8});
            end
            if (rx_valid[0]) rxv_cnt0++;
            if (rx_valid[1]) rxv_cnt1++;
        end
        if (flash_cs_n) begin
            if (!prev_cs) begin
                last_low_run = lo_cnt;
                n_rise++;
                rise_cyc = cyc;
            end
            hi_cnt++;
            lo_cnt = 0;
        end else begin
            if (prev_cs) last_high_run = hi_cnt;
            lo_cnt++;
            hi_cnt = 0;
        end
        prev_cs = flash_cs_n;
    end

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        while ((req_q0.size() + req_q1.size() + tx_q0.size() + tx_q1.size() + exp_tx.size()
                + exp_rx0.size() + exp_rx1.size() + exp_grant.size() != 0
                || req_valid != 2'b00 || !flash_cs_n || owner != 2'b00) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, {31'h0, n < budget}, 32'h1);
        repeat (c_CS_GAP + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        int base_start, base_ack, base_rise, base_rxv, n;
        logic stable;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n",      {31'h0, flash_cs_n}, 32'h1);
        check("rst_owner",     {30'h0, owner},      32'h0);
        check("rst_req_ack",   {30'h0, req_ack},    32'h0);
        check("rst_tx_ready",  {30'h0, tx_ready},   32'h0);
        check("rst_rx_valid",  {30'h0, rx_valid},   32'h0);
        check("rst_rx_data",   {24'h0, rx_data},    32'h0);
        check("rst_eng_start", {31'h0, eng_start},  32'h0);
        check("rst_eng_tx",    {24'h0, eng_tx},     32'h0);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Ties after reset: 0 first, then 1 back-to-back, then 0 again.
        req_q0.push_back('{16'd0, 16'd0});
        req_q1.push_back('{16'd0, 16'd0});
        exp_grant.push_back(2'b01);
        exp_grant.push_back(2'b10);
        wait_quiet("tie1_timeout", 200);
        check("b2b_cs_gap", last_high_run, c_CS_GAP);
        req_q0.push_back('{16'd0, 16'd0});
        req_q1.push_back('{16'd0, 16'd0});
        exp_grant.push_back(2'b01);
        exp_grant.push_back(2'b10);
        wait_quiet("tie2_timeout", 200);

        // Single UART read-ID style transfer.
        base_start = n_start;
        base_rise  = n_rise;
        tx_q0.push_back(8'h9F);
        req_q0.push_back('{16'd1, 16'd5});
        exp_grant.push_back(2'b01);
        foreach (exp_rx0[i]) ;
        eng_rx_q.push_back(8'h11);
        eng_rx_q.push_back(8'hEF); exp_rx0.push_back(8'hEF);
        eng_rx_q.push_back(8'h40); exp_rx0.push_back(8'h40);
        eng_rx_q.push_back(8'h16); exp_rx0.push_back(8'h16);
        eng_rx_q.push_back(8'h00); exp_rx0.push_back(8'h00);
        eng_rx_q.push_back(8'h00); exp_rx0.push_back(8'h00);
        exp_tx.push_back(8'h9F);
        for (int i = 0; i < 5; i++) exp_tx.push_back(8'h00);
        wait_quiet("uart_timeout", 2000);
        check("uart_starts", n_start - base_start, 6);
        check("uart_cs_rises", n_rise - base_rise, 1);

        // Zero-length transfer: one SETUP cycle with CS low, no engine use.
        base_start = n_start;
        base_ack   = n_ack;
        req_q0.push_back('{16'd0, 16'd0});
        exp_grant.push_back(2'b01);
        wait_quiet("zero_timeout", 200);
        check("zero_cs_low", last_low_run, 1);
        check("zero_starts", n_start - base_start, 0);
        check("zero_acks", n_ack - base_ack, 1);

        // Abort during the 2nd TX byte; I2C request pending behind it.
        base_start = n_start;
        base_rxv   = rxv_cnt0;
        tx_q0.push_back(8'hA1);
        tx_q0.push_back(8'hA2);
        tx_q0.push_back(8'hA3);
        req_q0.push_back('{16'd3, 16'd0});
        exp_grant.push_back(2'b01);
        exp_tx.push_back(8'hA1);
        exp_tx.push_back(8'hA2);
        n = 0;
        while (n_start != base_start + 2 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_wait_2nd", {31'h0, n < 500}, 32'h1);
        req_abort = 2'b01;
        @(posedge clk); #1;
        req_abort = 2'b00;
        check("abort_drain_cs", {31'h0, flash_cs_n}, 32'h0);
        tx_q0.delete();
        req_q1.push_back('{16'd0, 16'd0});
        exp_grant.push_back(2'b10);
        n = 0;
        while (!flash_cs_n && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk); #1;
        check("abort_cs_after_done", rise_cyc, last_done_cyc + 1);
        wait_quiet("abort_timeout", 500);
        check("abort_starts", n_start - base_start, 2);
        check("abort_no_rx", rxv_cnt0 - base_rxv, 0);

        // rx_len=1 with the consumer stalled for 50 cycles.
        base_start = n_start;
        rx_ready[0] = 1'b0;
        req_q0.push_back('{16'd0, 16'd1});
        exp_grant.push_back(2'b01);
        eng_rx_q.push_back(8'h3C);
        exp_tx.push_back(8'h00);
        exp_rx0.push_back(8'h3C);
        n = 0;
        while (!rx_valid[0] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("stall_rx_valid", {31'h0, rx_valid[0]}, 32'h1);
        base_rxv = rxv_cnt0;
        stable = 1'b1;
        repeat (50) begin
            @(posedge clk); #1;
            if (rx_data !== 8'h3C) stable = 1'b0;
        end
        check("stall_rxv_cycles", rxv_cnt0 - base_rxv, 50);
        check("stall_data_stable", {31'h0, stable}, 32'h1);
        check("stall_starts", n_start - base_start, 1);
        rx_ready[0] = 1'b1;
        wait_quiet("stall_timeout", 200);

        // Reset asserted while I2C sits in the RX phase.
        rx_ready[1] = 1'b0;
        req_q1.push_back('{16'd0, 16'd4});
        exp_grant.push_back(2'b10);
        eng_rx_q.push_back(8'h01);
        exp_tx.push_back(8'h00);
        n = 0;
        while (!rx_valid[1] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("rstmid_rx_valid", {31'h0, rx_valid[1]}, 32'h1);
        #3;
        resetn = 1'b0;
        #1;
        check("rstmid_cs_n",     {31'h0, flash_cs_n}, 32'h1);
        check("rstmid_owner",    {30'h0, owner},      32'h0);
        check("rstmid_rx_valid", {30'h0, rx_valid},   32'h0);
        exp_tx.delete(); exp_rx0.delete(); exp_rx1.delete();
        eng_rx_q.delete(); exp_grant.delete();
        req_q0.delete(); req_q1.delete(); tx_q0.delete(); tx_q1.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        rx_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        base_start = n_start;
        tx_q0.push_back(8'h77);
        req_q0.push_back('{16'd1, 16'd1});
        exp_grant.push_back(2'b01);
        eng_rx_q.push_back(8'h00);
        eng_rx_q.push_back(8'hC5);
        exp_tx.push_back(8'h77);
        exp_tx.push_back(8'h00);
        exp_rx0.push_back(8'hC5);
        wait_quiet("post_rst_timeout", 500);
        check("post_rst_starts", n_start - base_start, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_xfer_arbiter.md
# flash_xfer_arbiter

Shares the single SPI flash byte engine between the bootloader's two command front-ends: requester 0 is the UART command decoder and requester 1 is the I2C command decoder. It grants one complete flash transfer at a time using round-robin arbitration. It sequences each transfer as chip-select assert, TX-length bytes out, RX-length bytes in, then chip-select release, and honours a requester abort at any point.

## Interface
Parameters:
- LEN_W, 16, width of transfer length fields
- CS_GAP, 4, minimum cycles flash_cs_n stays high between transfers (≥1)
- RX_FILL, 8'h00, byte shifted out during the RX phase

Ports:
- clk  in  1  system clock; the only clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester transfer request, level, held until req_ack
- req_tx_len  in  2*LEN_W  TX byte count; requester i at [i*LEN_W +: LEN_W]
- req_rx_len  in  2*LEN_W  RX byte count, same packing
- req_ack  out  2  one-cycle grant pulse; lengths are latched in that cycle
- req_abort  in  2  abort the owner's transfer; ignored for non-owners
- tx_data  in  16  TX bytes; requester i at [8i +: 8]
- tx_valid  in  2  TX byte valid
- tx_ready  out  2  TX byte accepted; asserted only to the owner
- rx_data  out  8  RX byte, shared, qualified by rx_valid
- rx_valid  out  2  RX byte valid, owner bit only
- rx_ready  in  2  RX byte consumed
- owner  out  2  one-hot current owner, 0 when idle
- flash_cs_n  out  1  flash chip select
- eng_start  out  1  one-cycle pulse that starts a byte exchange
- eng_tx  out  8  byte to shift out; held stable from eng_start until eng_done
- eng_done  in  1  one-cycle pulse when the byte exchange completes
- eng_rx  in  8  byte shifted in; valid with eng_done

## Operation
- States: IDLE, SETUP, TX_WAIT, TX_SHIFT, RX_SHIFT, RX_HOLD, DRAIN, GAP.
- IDLE: if any req_valid is set, pick the winner, pulse req_ack[winner], latch both lengths into tx_cnt/rx_cnt, set owner, go to SETUP.
- Round-robin: a lone requester wins. On a tie, the winner is the requester not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
- SETUP: flash_cs_n is already low. If tx_cnt≠0, go to TX_WAIT. Else if rx_cnt≠0, go to RX_SHIFT. Else go to GAP.
- TX_WAIT: tx_ready[owner]=1. On tx_valid, capture the byte into eng_tx, pulse eng_start, decrement tx_cnt, go to TX_SHIFT.
- TX_SHIFT: wait for eng_done and discard eng_rx. Then go to TX_WAIT if tx_cnt≠0, else RX_SHIFT if rx_cnt≠0, else GAP.
- RX_SHIFT: on entry, pulse eng_start with eng_tx=RX_FILL and decrement rx_cnt. On eng_done, register eng_rx into rx_data and go to RX_HOLD.
- RX_HOLD: rx_valid[owner]=1. On rx_ready, go to RX_SHIFT if rx_cnt≠0, else GAP. The engine is never restarted until the owner consumes the byte.
- Abort:
  - In SETUP, TX_WAIT or RX_HOLD: go directly to GAP.
  - In TX_SHIFT or RX_SHIFT: go to DRAIN, wait for eng_done, drop the byte, then go to GAP.
  - The engine is never cut mid-byte.
- GAP: flash_cs_n=1 and owner=0 for CS_GAP cycles, then IDLE.
- Counters are LEN_W bits, with no wrap: the maximum is 2^LEN_W−1 bytes per phase.
- A req_valid from a non-owner during a transfer is held pending and is arbitrated in the next IDLE.
- eng_done outside TX_SHIFT, RX_SHIFT and DRAIN is ignored.

## Timing
- Reset values: state=IDLE, flash_cs_n=1, owner=0, req_ack=0, tx_ready=0, rx_valid=0, rx_data=0, eng_start=0, eng_tx=0, last-grant=1.
- Reset mid-transfer: all outputs return to reset values asynchronously, and flash_cs_n goes high immediately.
- Grant latency: req_valid high at edge N gives req_ack high in cycle N+1. flash_cs_n goes low and owner is valid from the same edge.
- flash_cs_n low to the first eng_start is ≥1 cycle, because SETUP always takes one cycle.
- TX handshake: a byte transfers on the edge where tx_valid&tx_ready are both high. eng_start follows on the next cycle.
- RX: rx_valid rises the cycle after eng_done. The byte transfers on the edge where rx_valid&rx_ready are both high. The next eng_start follows on the next cycle.
- Outputs are registered; the only combinational path is req_abort → next state.
- Back-to-back transfers: flash_cs_n is high for exactly CS_GAP cycles between transfers.

## Test plan
- Single UART transfer (tx_len=1, rx_len=5, TX byte 9F, engine returns EF,40,16,00,00): exactly 6 eng_start pulses; the first five RX-phase bytes… eng_tx=9F then RX_FILL×5; rx_valid[0] delivers EF,40,16,00,00; flash_cs_n low throughout, then high for 4 cycles.
- Simultaneous req_valid=2'b11 after reset: requester 0 is granted first and requester 1 after the GAP. A third tie after that is granted to 0.
- UART abort during the 2nd TX byte of a tx_len=3 transfer: exactly 2 eng_start pulses; flash_cs_n rises only after eng_done; no rx_valid; I2C's pending request is granted next.
- tx_len=0, rx_len=0: flash_cs_n low for exactly 1 cycle (SETUP); no eng_start; req_ack pulses once.
- rx_len=1 with rx_ready held low for 50 cycles: rx_valid stays high for 50 cycles, no second eng_start occurs, and data is stable.
- Assert resetn=0 mid RX phase: flash_cs_n=1 and owner=0 in the same cycle; after release, a new request is served normally.
